miriscv_lsu: RTL

Load-store unit between the core's execute stage and the data port of the single-port instruction/data RAM. Per load/store request it:
- drives the RAM data-port handshake (request, write enable, byte enables, word-aligned address, store data lane placement);
- stalls the core for the RAM's registered read;
- returns the load result, zero- or sign-extended.

It also flags misaligned and illegal-size accesses without touching memory.

---
 rtl/miriscv_lsu.sv | 81 ++++++++
 1 files changed

// File: rtl/miriscv_lsu.sv
// miriscv_lsu: load-store unit bridging the execute stage to the RAM data port.
// Two-state FSM: IDLE issues the access and stalls, WAIT returns the extended load data.
module miriscv_lsu (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_misalign_o,
    output logic        lsu_illegal_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WAIT = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [1:0]  off_q, size_q;
    logic        uns_q, we_q;
    logic        is_idle, illegal, misalign, issue;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ext_v;

    always_comb begin
        is_idle  = (state_q == IDLE) && !rst_i;
        illegal  = lsu_we_i ? (lsu_size_i[2] || lsu_size_i[1:0] == 2'b11)
                            : (lsu_size_i == 3'b011 || lsu_size_i[2:1] == 2'b11);
        misalign = (lsu_size_i[1:0] == 2'b01 && lsu_addr_i[0]) ||
                   (lsu_size_i[1:0] == 2'b10 && lsu_addr_i[1:0] != 2'b00);
        issue    = is_idle && lsu_req_i && !illegal && !misalign;
        state_d  = issue ? WAIT : IDLE;
        lsu_illegal_o   = is_idle && lsu_req_i && illegal;
        lsu_misalign_o  = is_idle && lsu_req_i && !illegal && misalign;
        lsu_stall_req_o = issue;
        data_req_o      = issue;
        data_we_o       = issue && lsu_we_i;
        data_addr_o     = issue ? {lsu_addr_i[31:2], 2'b00} : 32'd0;
        data_be_o       = !(issue && lsu_we_i) ? 4'b0000 :
                          lsu_size_i[1:0] == 2'b00 ? 4'b0001 << lsu_addr_i[1:0] :
                          lsu_size_i[1:0] == 2'b01 ? 4'b0011 << lsu_addr_i[1:0] : 4'b1111;
        data_wdata_o    = !(issue && lsu_we_i) ? 32'd0 :
                          lsu_size_i[1:0] == 2'b00 ? {4{lsu_data_i[7:0]}} :
                          lsu_size_i[1:0] == 2'b01 ? {2{lsu_data_i[15:0]}} : lsu_data_i;
    end

    // The RAM presents the addressed word in WAIT; pick the lane by the captured offset.
    always_comb begin
        byte_v     = 8'(data_rdata_i >> {off_q, 3'b000});
        half_v     = off_q[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        ext_v      = size_q == 2'b00 ? {{24{!uns_q && byte_v[7]}}, byte_v} :
                     size_q == 2'b01 ? {{16{!uns_q && half_v[15]}}, half_v} : data_rdata_i;
        lsu_data_o = (state_q == WAIT && !we_q && !rst_i) ? ext_v : 32'd0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                off_q  <= lsu_addr_i[1:0];
                size_q <= lsu_size_i[1:0];
                uns_q  <= lsu_size_i[2];
                we_q   <= lsu_we_i;
            end
        end
    end
endmodule
